packet_tx: RTL

Response packet transmitter for the UART ALU. It serializes a reply packet (opcode, reserved byte, 16-bit little-endian length, payload) into a byte stream for the UART transmitter, pulling payload from a 32-bit word stream supplied by the ECHO/ADD/MUL/DIV datapath. It is the transmit-side counterpart of the command packet parser and uses the same byte order and opcode encodings: ECHO 0xEC, ADD 0xAD, MUL 0x88, DIV 0xD1.

---
 rtl/packet_tx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/packet_tx.sv
// packet_tx: reply packet serializer (opcode, 0x00, LE length, payload); define PACKET_TX_CHECKSUM_EN to append an XOR trailer
module packet_tx #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [7:0]        opcode_i,
  input  logic [15:0]       payload_len_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic [WORD_W-1:0] word_i,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              busy_o,
  output logic              len_err_o
);
  localparam int NB = WORD_W / 8;
  localparam int CW = $clog2(NB + 1);
`ifdef PACKET_TX_CHECKSUM_EN
  localparam bit          CK   = 1'b1;
  localparam logic [15:0] MAXP = 16'hFFFA;
`else
  localparam bit          CK   = 1'b0;
  localparam logic [15:0] MAXP = 16'hFFFB;
`endif
  localparam logic [15:0] HDR = CK ? 16'd5 : 16'd4;
  typedef enum logic [2:0] {
    IDLE, TX_OPCODE, TX_RESERVED, TX_LENGTH_LSB, TX_LENGTH_MSB, LOAD_WORD, TX_PAYLOAD, TX_CHECKSUM
  } state_t;
  state_t            r_state, w_state_n, w_tail;
  logic [15:0]       r_len, r_rem, w_plen;
  logic [WORD_W-1:0] r_shift, w_shift_n;
  logic [CW-1:0]     r_cnt;
  logic [7:0]        r_csum, r_tx_data, w_data_n;
  logic              r_tx_valid, r_len_err, w_start, w_tx_hs, w_word_hs;
  assign w_start       = start_valid_i && r_state == IDLE;
  assign w_tx_hs       = r_tx_valid && tx_ready_i;
  assign w_word_hs     = word_valid_i && r_state == LOAD_WORD;
  assign w_plen        = payload_len_i > MAXP ? MAXP : payload_len_i;
  assign w_shift_n     = r_shift >> 8;
  assign w_tail        = CK ? TX_CHECKSUM : IDLE;
  assign start_ready_o = r_state == IDLE;
  assign word_ready_o  = r_state == LOAD_WORD;
  assign busy_o        = r_state != IDLE;
  assign tx_valid_o    = r_tx_valid;
  assign tx_data_o     = r_tx_data;
  assign len_err_o     = r_len_err;
  // next byte is computed alongside next state so tx_data_o can be a plain register
  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_tx_data;
    case (r_state)
      IDLE: if (w_start) begin
        w_state_n = TX_OPCODE;
        w_data_n  = opcode_i;
      end
      TX_OPCODE: if (w_tx_hs) begin
        w_state_n = TX_RESERVED;
        w_data_n  = 8'h00;
      end
      TX_RESERVED: if (w_tx_hs) begin
        w_state_n = TX_LENGTH_LSB;
        w_data_n  = r_len[7:0];
      end
      TX_LENGTH_LSB: if (w_tx_hs) begin
        w_state_n = TX_LENGTH_MSB;
        w_data_n  = r_len[15:8];
      end
      TX_LENGTH_MSB: if (w_tx_hs) begin
        w_state_n = r_rem == 16'd0 ? w_tail : LOAD_WORD;
        w_data_n  = r_csum ^ r_tx_data;
      end
      LOAD_WORD: if (w_word_hs) begin
        w_state_n = TX_PAYLOAD;
        w_data_n  = word_i[7:0];
      end
      TX_PAYLOAD: if (w_tx_hs) begin
        w_state_n = r_rem == 16'd1 ? w_tail : r_cnt == CW'(1) ? LOAD_WORD : TX_PAYLOAD;
        w_data_n  = r_rem == 16'd1 ? r_csum ^ r_tx_data : w_shift_n[7:0];
      end
      TX_CHECKSUM: if (w_tx_hs) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_len_err  <= 1'b0;
      r_len      <= 16'd0;
      r_rem      <= 16'd0;
      r_csum     <= 8'h00;
      r_shift    <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_tx_data  <= w_data_n;
      r_tx_valid <= !(w_state_n inside {IDLE, LOAD_WORD});
      r_len_err  <= w_start && payload_len_i > MAXP;
      if (w_start) begin
        r_len  <= w_plen + HDR;
        r_rem  <= w_plen;
        r_csum <= 8'h00;
      end else if (w_tx_hs) begin
        r_csum <= r_csum ^ r_tx_data;
      end
      if (w_word_hs) begin
        r_shift <= word_i;
        r_cnt   <= CW'(NB);
      end else if (w_tx_hs && r_state == TX_PAYLOAD) begin
        r_shift <= w_shift_n;
        r_cnt   <= r_cnt - CW'(1);
        r_rem   <= r_rem - 16'd1;
      end
    end
  end
endmodule
